// File: rtl/lcd_bus_ctrl.sv
// lcd_bus_ctrl: write-only HD44780-style LCD bus sequencer.
//   Takes one byte per request and drives RS/D/E with setup, pulse-width,
//   hold and (in 4-bit mode) inter-nibble gap timing. It then waits out the
//   LCD execution time before signalling completion.
// Ports:
//   clk, reset          system clock (rising edge), async active-high reset
//   start, CS           request strobe; accepted only in IDLE with CS=1
//   RS, data, nib_only  request payload, latched on the accepting edge
//   busy, done          busy outside IDLE; done is a one-cycle pulse in DONE
//   LCD_RS/RW/E/D       LCD bus; RW is tied low (write only)
module lcd_bus_ctrl #(
    parameter int BUS_W  = 8,
    parameter int T_SU   = 3,
    parameter int T_PW   = 12,
    parameter int T_HD   = 1,
    parameter int T_GAP  = 50,
    parameter int T_EXEC = 2000,
    parameter int T_CLR  = 82000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       CS,
    input  logic       RS,
    input  logic [7:0] data,
    input  logic       nib_only,
    output logic       busy,
    output logic       done,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_E,
    output logic [7:0] LCD_D
);

    localparam int M1   = (T_SU   > T_PW)  ? T_SU   : T_PW;
    localparam int M2   = (M1     > T_HD)  ? M1     : T_HD;
    localparam int M3   = (M2     > T_GAP) ? M2     : T_GAP;
    localparam int M4   = (M3     > T_EXEC)? M3     : T_EXEC;
    localparam int MAXT = (M4     > T_CLR) ? M4     : T_CLR;
    localparam int CW   = $clog2(MAXT + 1);

    typedef enum logic [2:0] {
        IDLE, SETUP, EHI, HOLD, GAP, WAIT, DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rs_q, rs_d;
    logic [7:0]    data_q, data_d;
    logic          nib_q, nib_d;
    logic          second_q, second_d;   // second nibble is on the bus
    logic [31:0]   lim;                  // length of the current state
    logic          last;                 // final cycle of the current state
    logic          long_wait;            // clear / home need the longer wait

    // Clear is exactly 0x01; home is 0x02/0x03 (bit 0 don't-care).
    assign long_wait = !rs_q && ((data_q[7:1] == 7'b0000000 && data_q[0]) ||
                                 (data_q[7:1] == 7'b0000001));

    assign last = ({{(32-CW){1'b0}}, cnt_q} == lim - 32'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rs_q     <= 1'b0;
            data_q   <= 8'h00;
            nib_q    <= 1'b0;
            second_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rs_q     <= rs_d;
            data_q   <= data_d;
            nib_q    <= nib_d;
            second_q <= second_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        rs_d     = rs_q;
        data_d   = data_q;
        nib_d    = nib_q;
        second_d = second_q;
        lim      = 32'd1;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start && CS) begin
                    state_d  = SETUP;
                    rs_d     = RS;
                    data_d   = data;
                    nib_d    = nib_only;
                    second_d = 1'b0;
                end
            end
            SETUP: begin
                lim = 32'(T_SU);
                if (last) begin
                    state_d = EHI;
                    cnt_d   = '0;
                end
            end
            EHI: begin
                lim = 32'(T_PW);
                if (last) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                lim = 32'(T_HD);
                if (last) begin
                    cnt_d = '0;
                    if (BUS_W == 4 && !second_q && !nib_q) begin
                        state_d  = GAP;
                        second_d = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            GAP: begin
                lim = 32'(T_GAP);
                if (last) begin
                    state_d = EHI;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                lim = long_wait ? 32'(T_CLR) : 32'(T_EXEC);
                if (last) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign LCD_E  = (state_q == EHI);
    assign LCD_RW = 1'b0;
    assign LCD_RS = rs_q;
    assign LCD_D  = (BUS_W == 4) ? (second_q ? {data_q[3:0], 4'b0000}
                                             : {data_q[7:4], 4'b0000})
                                 : data_q;

endmodule

// File: tb/tb_lcd_bus_ctrl.sv
module tb_lcd_bus_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start8, start4, cs, rs, nib;
    logic [7:0] data;
    logic       busy8, done8, lrs8, rw8, e8;
    logic [7:0] d8;
    logic       busy4, done4, lrs4, rw4, e4;
    logic [7:0] d4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lcd_bus_ctrl #(.BUS_W(8), .T_SU(1), .T_PW(2), .T_HD(1), .T_GAP(2),
                   .T_EXEC(4), .T_CLR(10)) u8 (
        .clk(clk), .reset(reset), .start(start8), .CS(cs), .RS(rs),
        .data(data), .nib_only(nib), .busy(busy8), .done(done8),
        .LCD_RS(lrs8), .LCD_RW(rw8), .LCD_E(e8), .LCD_D(d8));

    lcd_bus_ctrl #(.BUS_W(4), .T_SU(1), .T_PW(2), .T_HD(1), .T_GAP(2),
                   .T_EXEC(4), .T_CLR(10)) u4 (
        .clk(clk), .reset(reset), .start(start4), .CS(cs), .RS(rs),
        .data(data), .nib_only(nib), .busy(busy4), .done(done4),
        .LCD_RS(lrs4), .LCD_RW(rw4), .LCD_E(e4), .LCD_D(d4));

    typedef struct {
        logic       b4;
        logic       cs;
        logic       rs;
        logic [7:0] d;
        logic       nib;
        int         exp_done;    // cycle of done after the accept cycle; 0 = none
        int         exp_pulses;
        logic [7:0] exp_d1;
        logic [7:0] exp_d2;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int         pulses = 0, ecyc = 0, dcyc = 0, limit;
        logic [7:0] dcap[2];
        logic       pe = 1'b0, rsbad = 1'b0, rwbad = 1'b0, bever = 1'b0;
        logic       ob, od, ors, orw, oe;
        logic [7:0] odd;
        dcap[0] = 8'h00;
        dcap[1] = 8'h00;
        @(negedge clk);
        cs = v.cs; rs = v.rs; data = v.d; nib = v.nib;
        if (v.b4) start4 = 1'b1; else start8 = 1'b1;
        limit = (v.exp_done != 0) ? v.exp_done + 1 : 25;
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            if (v.b4) begin ob = busy4; od = done4; ors = lrs4; orw = rw4; oe = e4; odd = d4; end
            else      begin ob = busy8; od = done8; ors = lrs8; orw = rw8; oe = e8; odd = d8; end
            if (c == 1) begin
                // payload changes after accept must not reach the bus
                start8 = 1'b0; start4 = 1'b0; rs = ~rs; data = ~data;
            end
            if (oe && !pe) begin
                if (pulses < 2) dcap[pulses] = odd;
                pulses++;
            end
            if (oe) begin
                ecyc++;
                if (ors !== v.rs) rsbad = 1'b1;
            end
            if (orw !== 1'b0) rwbad = 1'b1;
            if (ob) bever = 1'b1;
            if (od && dcyc == 0) dcyc = c;
            if (c == limit && v.exp_done != 0) chk({tag, "_busy_after"}, 32'(ob), 32'd0);
            pe = oe;
        end
        chk({tag, "_done_cyc"}, dcyc, v.exp_done);
        chk({tag, "_pulses"}, pulses, v.exp_pulses);
        chk({tag, "_e_cycles"}, ecyc, v.exp_pulses * 2);
        chk({tag, "_rw"}, 32'(rwbad), 32'd0);
        if (v.exp_pulses >= 1) begin
            chk({tag, "_d1"}, 32'(dcap[0]), 32'(v.exp_d1));
            chk({tag, "_rs"}, 32'(rsbad), 32'd0);
        end
        if (v.exp_pulses == 2) chk({tag, "_d2"}, 32'(dcap[1]), 32'(v.exp_d2));
        if (v.exp_done == 0) chk({tag, "_no_busy"}, 32'(bever), 32'd0);
    endtask

    initial begin
        int nd, np, ni, nb, d2c;
        //            b4    cs    rs    d      nib   done pul d1     d2
        tbl[0]  = '{1'b0, 1'b1, 1'b1, 8'h59, 1'b0,  9, 1, 8'h59, 8'h00};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 14, 2, 8'hA0, 8'h50};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 8'h30, 1'b1,  9, 1, 8'h30, 8'h00};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 8'h01, 1'b0, 15, 1, 8'h01, 8'h00};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 8'h01, 1'b0,  9, 1, 8'h01, 8'h00};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 8'h02, 1'b0, 15, 1, 8'h02, 8'h00};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 8'h03, 1'b0, 15, 1, 8'h03, 8'h00};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0,  9, 1, 8'h00, 8'h00};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 8'h04, 1'b0,  9, 1, 8'h04, 8'h00};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 8'h01, 1'b0, 20, 2, 8'h00, 8'h10};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 8'hC3, 1'b1,  9, 1, 8'hC3, 8'h00};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 8'h3F, 1'b1,  9, 1, 8'h30, 8'h00};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 8'h01, 1'b1, 15, 1, 8'h00, 8'h00};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 8'h77, 1'b0,  0, 0, 8'h00, 8'h00};

        reset = 1'b1; start8 = 1'b0; start4 = 1'b0; cs = 1'b0; rs = 1'b0;
        data = 8'h00; nib = 1'b0;
        #1;
        chk("rst_busy8", 32'(busy8), 32'd0);
        chk("rst_done8", 32'(done8), 32'd0);
        chk("rst_e8",    32'(e8),    32'd0);
        chk("rst_d8",    32'(d8),    32'd0);
        chk("rst_rs8",   32'(lrs8),  32'd0);
        chk("rst_busy4", 32'(busy4), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // start held high: one accept per IDLE visit, period 10 cycles
        @(negedge clk);
        cs = 1'b1; rs = 1'b1; data = 8'h59; nib = 1'b0; start8 = 1'b1;
        nd = 0; np = 0; ni = 0;
        begin
            logic pe = 1'b0;
            for (int c = 1; c <= 40; c++) begin
                @(negedge clk);
                if (done8) nd++;
                if (e8 && !pe) np++;
                if (!busy8) ni++;
                pe = e8;
            end
        end
        start8 = 1'b0;
        chk("held_dones", nd, 4);
        chk("held_pulses", np, 4);
        chk("held_idles", ni, 4);
        @(negedge clk);
        chk("held_release_idle", 32'(busy8), 32'd0);

        // starts during WAIT and DONE only: ignored, not queued
        @(negedge clk);
        start8 = 1'b1;
        nd = 0; np = 0; nb = 0;
        begin
            logic pe = 1'b0;
            for (int c = 1; c <= 20; c++) begin
                @(negedge clk);
                if (done8) nd++;
                if (e8 && !pe) np++;
                if (busy8) nb++;
                pe = e8;
                if (c == 1 || c == 6 || c == 9) start8 = 1'b0;
                if (c == 5 || c == 8) start8 = 1'b1;
            end
        end
        chk("ign_dones", nd, 1);
        chk("ign_pulses", np, 1);
        chk("ign_busy_cycles", nb, 9);

        // start held over DONE into IDLE: accepted one cycle after done
        @(negedge clk);
        start8 = 1'b1;
        nd = 0; np = 0; d2c = 0;
        begin
            logic pe = 1'b0;
            for (int c = 1; c <= 21; c++) begin
                @(negedge clk);
                if (done8) begin nd++; if (c > 9) d2c = c; end
                if (e8 && !pe) np++;
                if (c == 10) chk("b2b_idle_gap", 32'(busy8), 32'd0);
                pe = e8;
                if (c == 1 || c == 11) start8 = 1'b0;
                if (c == 8) start8 = 1'b1;
            end
        end
        chk("b2b_dones", nd, 2);
        chk("b2b_pulses", np, 2);
        chk("b2b_second_done", d2c, 19);

        // async reset while E is high
        @(negedge clk);
        rs = 1'b1; data = 8'h59; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        chk("pre_reset_e", 32'(e8), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_e", 32'(e8), 32'd0);
        chk("arst_busy", 32'(busy8), 32'd0);
        chk("arst_d", 32'(d8), 32'd0);
        chk("arst_rs", 32'(lrs8), 32'd0);
        nd = 0;
        repeat (3) begin
            @(negedge clk);
            if (done8 || busy8) nd++;
        end
        chk("arst_no_done", nd, 0);
        reset = 1'b0;
        run_vec(tbl[0], "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
